mmio_responder: RTL and testbench
=================================

Name: mmio_responder

Overview:
- Responder side of the processor's data-memory bus for the memory-mapped board I/O: KEY, SW, HEX, LEDR, LEDG.
- Sits beside data memory in the top level; the core drives address/write-enable/write-data and muxes `rdata` in when `hit` is high.
- Owns the output registers for HEX/LEDR/LEDG.
- Synchronises and debounces the KEY and SW inputs.

Parameters:
- DBITS, 32, data/address bus width
- ADDR_HEX, 32'hF0000000, HEX register address (R/W)
- ADDR_LEDR, 32'hF0000004, LEDR register address (R/W)
- ADDR_LEDG, 32'hF0000008, LEDG register address (R/W)
- ADDR_KEY, 32'hF0000010, KEY status address (RO)
- ADDR_SW, 32'hF0000014, SW status address (RO)
- DEBOUNCE_CYCLES, 16'd50000, stable synchronised samples required before a debounced bit changes (≥1)

Ports:
- clk  in  1  system clock (PLL c0)
- reset  in  1  asynchronous, active-low reset; top drives it with PLL `lock`
- addr  in  DBITS  byte address from the core (bits [1:0] ignored)
- wr_en  in  1  store strobe, sampled at posedge clk
- wdata  in  DBITS  store data
- rdata  out  DBITS  combinational read data for `addr`
- hit  out  1  combinational; 1 when `addr` matches any of the five addresses
- key_n  in  4  raw board KEY, active-low, asynchronous
- sw  in  10  raw board SW, asynchronous
- hex0, hex1, hex2, hex3  out  7 each  seven-segment drive, active-low, bit0 = seg a … bit6 = seg g
- ledr  out  10  LEDR register
- ledg  out  8  LEDG register

Behaviour:
- Reset (reset==0, asynchronous):
  - hex_reg=16'h0, so hex0..3 = 7'b1000000 ("0").
  - ledr=0, ledg=0.
  - Synchroniser flops = 0.
  - Debounced key=0 (not pressed), debounced sw=0.
  - Debounce counters = 0.
  - Deassertion takes effect at the next clk edge; mid-operation reset discards any in-progress debounce.
- Address compare:
  - Full DBITS compare with addr[1:0] masked.
  - `hit` and `rdata` are purely combinational.
  - Unmatched address: hit=0, rdata=0.
- Writes (posedge clk, wr_en && hit):
  - HEX: hex_reg <= wdata[15:0].
  - LEDR: ledr <= wdata[9:0].
  - LEDG: ledg <= wdata[7:0].
  - Writes to KEY/SW, and writes with hit=0, are ignored.
  - A write is visible on rdata and the board outputs the cycle after the edge.
- Reads (zero-extended):
  - HEX returns {16'b0,hex_reg}.
  - LEDR returns {22'b0,ledr}.
  - LEDG returns {24'b0,ledg}.
  - KEY returns {28'b0,key_db}, where 1 = pressed (key_n is inverted before synchronising).
  - SW returns {22'b0,sw_db}.
- Synchronisers: a 2-flop synchroniser on each of the 14 input bits.
- Debounce, per bit, with synchronised sample s, debounced value d, and counter c:
  - If s==d: c<=0.
  - Else if c==DEBOUNCE_CYCLES-1: d<=s, c<=0.
  - Else: c<=c+1.
  - Consequence: a clean input step is reflected in d exactly 2+DEBOUNCE_CYCLES edges later.
  - A glitch shorter than DEBOUNCE_CYCLES samples never changes d; the counter restarts whenever s returns to d.
- Counter width: $clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
- A read of KEY/SW on the same cycle d updates returns the pre-edge value.
- A simultaneous write and read at the same address in one cycle: rdata shows the old value until the edge.
- Seven-segment decode: nibble n of hex_reg drives hexn through a combinational decoder covering all 16 hex digits, 0-F.

Decomposition:
- Shared package/include: the five address constants, DBITS, the seven-segment pattern constants for 0-F, and DEBOUNCE_CYCLES default.
- Sub-module `seven_seg_decoder` (4-bit in, 7-bit active-low out), instantiated four times.
- Debounce logic: a generate loop inside mmio_responder, not a separate module.

Test Plan:
- Reset, then read with no stimulus:
  - Read 0xF0000000 → rdata=0, hit=1.
  - hex0..3=7'b1000000; ledr=0, ledg=0.
- Write 0xF0000000 ← 32'hDEADBEEF:
  - Next cycle read → 32'h0000BEEF.
  - hex3..hex0 show B,E,E,F: 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110.
- Write LEDR ← 32'hFFFFFFFF and LEDG ← 32'h12345:
  - ledr=10'h3FF, ledg=8'h45.
  - Reads return 32'h3FF and 32'h45.
  - Write to 0xF0000010 ← 32'hF leaves KEY read unchanged.
- DEBOUNCE_CYCLES=4, key_n[2] falls and holds:
  - KEY read = 32'h4 exactly 6 edges later; 0 before.
  - A 3-cycle key_n[1] low pulse never appears.
- sw=10'h2A5 held: after 6 edges, SW read = 32'h2A5.
  - Assert reset mid-count on a later sw change → debounced sw returns 0 immediately.
- addr=0xF000000C and addr=0x00000100:
  - hit=0, rdata=0.
  - A wr_en pulse changes no output register.

Source files
------------

// File: rtl/mmio_responder_pkg.sv
//------------------------------------------------------------------------------
// Module   : mmio_responder_pkg
// Brief    : Shared constants and segment patterns for the board I/O responder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mmio_responder_pkg;

    localparam int          DBITS           = 32;
    localparam logic [31:0] ADDR_HEX        = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR       = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG       = 32'hF000_0008;
    localparam logic [31:0] ADDR_KEY        = 32'hF000_0010;
    localparam logic [31:0] ADDR_SW         = 32'hF000_0014;
    localparam logic [15:0] DEBOUNCE_CYCLES = 16'd50000;

    localparam int KEY_BITS = 4;
    localparam int SW_BITS  = 10;

    // Active-low segments, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
        logic [6:0] pat;
        pat = SEG_0;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_responder_seven_seg_decoder.sv
//------------------------------------------------------------------------------
// Module   : seven_seg_decoder
// Brief    : Combinational hex digit to active-low seven-segment pattern.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seven_seg_decoder
    import mmio_responder_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg_pattern(nibble);

endmodule

`default_nettype wire

// File: rtl/mmio_responder.sv
//------------------------------------------------------------------------------
// Module   : mmio_responder
// Brief    : Memory-mapped KEY/SW/HEX/LEDR/LEDG responder on the data bus.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mmio_responder #(
    parameter int                DBITS           = mmio_responder_pkg::DBITS,
    parameter logic [DBITS-1:0]  ADDR_HEX        = mmio_responder_pkg::ADDR_HEX,
    parameter logic [DBITS-1:0]  ADDR_LEDR       = mmio_responder_pkg::ADDR_LEDR,
    parameter logic [DBITS-1:0]  ADDR_LEDG       = mmio_responder_pkg::ADDR_LEDG,
    parameter logic [DBITS-1:0]  ADDR_KEY        = mmio_responder_pkg::ADDR_KEY,
    parameter logic [DBITS-1:0]  ADDR_SW         = mmio_responder_pkg::ADDR_SW,
    parameter logic [15:0]       DEBOUNCE_CYCLES = mmio_responder_pkg::DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic             wr_en,
    input  logic [DBITS-1:0] wdata,
    output logic [DBITS-1:0] rdata,
    output logic             hit,
    input  logic [3:0]       key_n,
    input  logic [9:0]       sw,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [9:0]       ledr,
    output logic [7:0]       ledg
);

    import mmio_responder_pkg::*;

    localparam int              NIN      = KEY_BITS + SW_BITS;
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 16'd1);

    logic [DBITS-1:0]    word_addr;
    logic                sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw;
    logic [15:0]         hex_reg;
    logic [NIN-1:0]      raw_in, sync_meta, sync_q, db;
    logic [KEY_BITS-1:0] key_db;
    logic [SW_BITS-1:0]  sw_db;
    logic                unused_bits;

    assign word_addr = {addr[DBITS-1:2], 2'b00};
    assign sel_hex   = (word_addr == {ADDR_HEX[DBITS-1:2],  2'b00});
    assign sel_ledr  = (word_addr == {ADDR_LEDR[DBITS-1:2], 2'b00});
    assign sel_ledg  = (word_addr == {ADDR_LEDG[DBITS-1:2], 2'b00});
    assign sel_key   = (word_addr == {ADDR_KEY[DBITS-1:2],  2'b00});
    assign sel_sw    = (word_addr == {ADDR_SW[DBITS-1:2],   2'b00});
    assign hit       = sel_hex | sel_ledr | sel_ledg | sel_key | sel_sw;

    assign unused_bits = &{1'b0, addr[1:0], wdata[DBITS-1:16]};

    always_comb begin
        rdata = '0;
        if (sel_hex)       rdata = DBITS'(hex_reg);
        else if (sel_ledr) rdata = DBITS'(ledr);
        else if (sel_ledg) rdata = DBITS'(ledg);
        else if (sel_key)  rdata = DBITS'(key_db);
        else if (sel_sw)   rdata = DBITS'(sw_db);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hex_reg <= '0;
            ledr    <= '0;
            ledg    <= '0;
        end else if (wr_en) begin
            if (sel_hex)  hex_reg <= wdata[15:0];
            if (sel_ledr) ledr    <= wdata[9:0];
            if (sel_ledg) ledg    <= wdata[7:0];
        end
    end

    // KEY is inverted up front so every downstream bit reads 1 = active
    assign raw_in = {sw, ~key_n};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= raw_in;
            sync_q    <= sync_meta;
        end
    end

    generate
        for (genvar i = 0; i < NIN; i++) begin : g_debounce
            logic [CW-1:0] cnt;
            logic          d;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt <= '0;
                    d   <= 1'b0;
                end else if (sync_q[i] == d) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    d   <= sync_q[i];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign db[i] = d;
        end
    endgenerate

    assign key_db = db[KEY_BITS-1:0];
    assign sw_db  = db[NIN-1:KEY_BITS];

    seven_seg_decoder u_seg0 (.nibble(hex_reg[3:0]),   .seg(hex0));
    seven_seg_decoder u_seg1 (.nibble(hex_reg[7:4]),   .seg(hex1));
    seven_seg_decoder u_seg2 (.nibble(hex_reg[11:8]),  .seg(hex2));
    seven_seg_decoder u_seg3 (.nibble(hex_reg[15:12]), .seg(hex3));

endmodule

`default_nettype wire

// File: tb/tb_mmio_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_mmio_responder
// Brief    : Scoreboard bench for mmio_responder against a behavioural model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mmio_responder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        wr_en = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        hit;
    logic [3:0]  key_n = 4'hF;
    logic [9:0]  sw = 10'h0;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    mmio_responder #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
        .rdata(rdata), .hit(hit), .key_n(key_n), .sw(sw),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .ledr(ledr), .ledg(ledg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        hit;
        logic [6:0]  h0, h1, h2, h3;
        logic [9:0]  ledr;
        logic [7:0]  ledg;
    } exp_t;

    exp_t        sbq[$];
    logic        sample_req = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Behavioural model: register contents plus a history of raw inputs
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [13:0] m_db;
    logic [13:0] hist[$];

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic model_clear();
        m_hex = 16'h0; m_ledr = 10'h0; m_ledg = 8'h0; m_db = 14'h0;
        hist.delete();
        for (int i = 0; i < N + 2; i++) hist.push_back(14'h0);
    endtask

    // Returns {hit, data} for a bus address given the current model state
    function automatic logic [32:0] model_read(input logic [31:0] a);
        case ({a[31:2], 2'b00})
            32'hF000_0000: return {1'b1, 16'h0, m_hex};
            32'hF000_0004: return {1'b1, 22'h0, m_ledr};
            32'hF000_0008: return {1'b1, 24'h0, m_ledg};
            32'hF000_0010: return {1'b1, 28'h0, m_db[3:0]};
            32'hF000_0014: return {1'b1, 22'h0, m_db[13:4]};
            default:       return 33'h0;
        endcase
    endfunction

    // One clock edge of the model. A bit flips once the N most recent samples
    // seen through the two synchroniser stages all disagree with it.
    task automatic model_tick();
        logic [13:0] nd;
        logic        flip;
        if (!reset) begin
            model_clear();
            return;
        end
        hist.push_back({sw, ~key_n});
        nd = m_db;
        for (int b = 0; b < 14; b++) begin
            flip = 1'b1;
            for (int j = 0; j < N; j++)
                if (hist[hist.size() - 3 - j][b] == m_db[b]) flip = 1'b0;
            if (flip) nd[b] = ~m_db[b];
        end
        while (hist.size() > 32) void'(hist.pop_front());
        if (wr_en) begin
            case ({addr[31:2], 2'b00})
                32'hF000_0000: m_hex  = wdata[15:0];
                32'hF000_0004: m_ledr = wdata[9:0];
                32'hF000_0008: m_ledg = wdata[7:0];
                default: ;
            endcase
        end
        m_db = nd;
    endtask

    task automatic step(input string nm, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic [3:0] kn, input logic [9:0] s,
                        input logic rst_v, input bit use_lit,
                        input logic [31:0] lit_rd, input logic lit_hit);
        exp_t        e;
        logic [32:0] r;
        @(posedge clk);
        model_tick();
        #1;
        addr = a; wr_en = we; wdata = wd; key_n = kn; sw = s; reset = rst_v;
        #1;
        if (!rst_v) model_clear();
        r = model_read(a);
        e.name = nm;
        e.rdata = use_lit ? lit_rd : r[31:0];
        e.hit = use_lit ? lit_hit : r[32];
        e.h0 = seg(m_hex[3:0]);   e.h1 = seg(m_hex[7:4]);
        e.h2 = seg(m_hex[11:8]);  e.h3 = seg(m_hex[15:12]);
        e.ledr = m_ledr; e.ledg = m_ledg;
        sbq.push_back(e);
        sample_req = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sample_req) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, ".rdata"}, rdata, e.rdata);
                chk({e.name, ".hit"}, {31'h0, hit}, {31'h0, e.hit});
                chk({e.name, ".hex"}, {4'h0, hex3, hex2, hex1, hex0},
                    {4'h0, e.h3, e.h2, e.h1, e.h0});
                chk({e.name, ".leds"}, {14'h0, ledr, ledg}, {14'h0, e.ledr, e.ledg});
            end
        end
    end

    logic [31:0] alist[7] = '{32'hF000_0000, 32'hF000_0004, 32'hF000_0008,
                              32'hF000_0010, 32'hF000_0014, 32'hF000_000C, 32'h0000_0100};

    initial begin
        logic [3:0]  kn;
        logic [9:0]  s;
        logic [31:0] a;
        model_clear();
        kn = 4'hF; s = 10'h0;

        step("rst_hold", 32'hF000_0000, 0, 0, kn, s, 0, 1, 32'h0, 1);
        step("rst_hold2", 32'hF000_0000, 0, 0, kn, s, 0, 1, 32'h0, 1);
        step("rst_rel", 32'hF000_0000, 0, 0, kn, s, 1, 1, 32'h0, 1);

        step("hex_wr", 32'hF000_0000, 1, 32'hDEAD_BEEF, kn, s, 1, 1, 32'h0, 1);
        step("hex_rd", 32'hF000_0001, 0, 0, kn, s, 1, 1, 32'h0000_BEEF, 1);
        step("ledr_wr", 32'hF000_0004, 1, 32'hFFFF_FFFF, kn, s, 1, 1, 32'h0, 1);
        step("ledg_wr", 32'hF000_0008, 1, 32'h0001_2345, kn, s, 1, 1, 32'h0, 1);
        step("ledr_rd", 32'hF000_0004, 0, 0, kn, s, 1, 1, 32'h3FF, 1);
        step("ledg_rd", 32'hF000_000B, 0, 0, kn, s, 1, 1, 32'h45, 1);
        step("key_wr", 32'hF000_0010, 1, 32'hF, kn, s, 1, 1, 32'h0, 1);
        step("key_rd", 32'hF000_0010, 0, 0, kn, s, 1, 1, 32'h0, 1);

        kn = 4'b1011;
        step("key2_t0", 32'hF000_0010, 0, 0, kn, s, 1, 1, 32'h0, 1);
        for (int t = 1; t <= 6; t++)
            step($sformatf("key2_t%0d", t), 32'hF000_0010, 0, 0, kn, s, 1, 1,
                 (t == 6) ? 32'h4 : 32'h0, 1);
        kn = 4'b1001;
        for (int t = 0; t < 3; t++)
            step("key1_glitch", 32'hF000_0010, 0, 0, kn, s, 1, 1, 32'h4, 1);
        kn = 4'b1011;
        for (int t = 0; t < 10; t++)
            step("key1_after", 32'hF000_0010, 0, 0, kn, s, 1, 1, 32'h4, 1);

        s = 10'h2A5;
        step("sw_t0", 32'hF000_0014, 0, 0, kn, s, 1, 1, 32'h0, 1);
        for (int t = 1; t <= 6; t++)
            step($sformatf("sw_t%0d", t), 32'hF000_0014, 0, 0, kn, s, 1, 1,
                 (t == 6) ? 32'h2A5 : 32'h0, 1);
        s = 10'h15A;
        for (int t = 0; t < 3; t++)
            step("sw_midcount", 32'hF000_0014, 0, 0, kn, s, 1, 1, 32'h2A5, 1);
        step("sw_rst", 32'hF000_0014, 0, 0, kn, s, 0, 1, 32'h0, 1);
        step("sw_rst_hold", 32'hF000_0014, 0, 0, kn, s, 0, 1, 32'h0, 1);
        step("sw_rst_rel", 32'hF000_0014, 0, 0, kn, s, 1, 1, 32'h0, 1);
        for (int t = 0; t < 8; t++)
            step("sw_resettle", 32'hF000_0014, 0, 0, kn, s, 1, 0, 32'h0, 0);

        step("ledr_set", 32'hF000_0004, 1, 32'h155, kn, s, 1, 0, 32'h0, 0);
        step("unmap_c", 32'hF000_000C, 1, 32'hFFFF_FFFF, kn, s, 1, 1, 32'h0, 0);
        step("unmap_100", 32'h0000_0100, 1, 32'hFFFF_FFFF, kn, s, 1, 1, 32'h0, 0);
        step("unmap_after", 32'hF000_0004, 0, 0, kn, s, 1, 1, 32'h155, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) kn = 4'($urandom);
            if ($urandom_range(0, 5) == 0) s = 10'($urandom);
            a = alist[$urandom_range(0, 6)] | 32'($urandom_range(0, 3));
            step("rand", a, 1'($urandom_range(0, 2) == 0), $urandom, kn, s, 1, 0, 32'h0, 0);
        end

        @(negedge clk);
        #1;
        sample_req = 1'b0;
        chk("scoreboard_drain", 32'(sbq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
